// File: rtl/nios_ii_music_sequencer.sv
// Avalon-MM note sequencer: a FIFO of {duration, note} words played back-to-back on out_port.
// Optional registered interrupt when idle and empty is enabled by defining NIOS_MUSIC_SEQ_IRQ_EN.
module nios_ii_music_sequencer #(
    parameter int DATA_W   = 16,
    parameter int DUR_W    = 16,
    parameter int DEPTH    = 16,
    parameter int TICK_DIV = 50000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [DATA_W-1:0] out_port,
    output logic              note_valid,
    output logic              note_start,
    output logic              irq
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int FW = DATA_W + DUR_W;

    typedef enum logic {S_IDLE, S_PLAY} state_t;

    state_t              r_state, w_state_nxt;
    logic [FW-1:0]       r_mem [DEPTH];
    logic [AW-1:0]       r_wr_ptr, r_rd_ptr;
    logic [LW-1:0]       r_level;
    logic                r_run, r_ovf, r_note_start;
    logic [DATA_W-1:0]   r_rest, r_note;
    logic [DUR_W-1:0]    r_dur_cnt;
    logic [PW-1:0]       r_presc;

    logic                w_wr, w_push_req, w_push, w_pop, w_flush;
    logic                w_empty, w_full, w_tick, w_irq_en;
    logic [FW-1:0]       w_head;
    logic [DATA_W-1:0]   w_head_note;
    logic [DUR_W-1:0]    w_head_dur;

    assign w_wr        = chipselect && !write_n;
    assign w_push_req  = w_wr && (address == 2'd0);
    assign w_flush     = w_wr && (address == 2'd1) && writedata[1];
    assign w_empty     = (r_level == '0);
    assign w_full      = (r_level == LW'(DEPTH));
    // Flush beats a simultaneous push; full is judged before any pop on the same edge.
    assign w_push      = w_push_req && !w_full && !w_flush;
    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_note = w_head[DATA_W-1:0];
    assign w_head_dur  = w_head[FW-1:DATA_W];
    assign w_tick      = (r_presc == PW'(TICK_DIV - 1));

    assign out_port    = (r_state == S_PLAY) ? r_note : r_rest;
    assign note_valid  = (r_state == S_PLAY);
    assign note_start  = r_note_start;

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_flush && r_run && !w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_PLAY;
                end
            end
            S_PLAY: begin
                if (w_flush || !r_run) begin
                    w_state_nxt = S_IDLE;
                end else if (w_tick && (r_dur_cnt == DUR_W'(1))) begin
                    if (!w_empty) w_pop = 1'b1;
                    else          w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_n && w_push) r_mem[r_wr_ptr] <= writedata[FW-1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_run        <= 1'b0;
            r_ovf        <= 1'b0;
            r_note_start <= 1'b0;
            r_rest       <= '0;
            r_note       <= '0;
            r_dur_cnt    <= '0;
            r_presc      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_note_start <= w_pop;

            if (w_pop) begin
                r_note    <= w_head_note;
                r_dur_cnt <= (w_head_dur == '0) ? DUR_W'(1) : w_head_dur;
                r_presc   <= '0;
            end else if (r_state == S_PLAY) begin
                if (w_tick) begin
                    r_presc   <= '0;
                    r_dur_cnt <= r_dur_cnt - DUR_W'(1);
                end else begin
                    r_presc <= r_presc + PW'(1);
                end
            end

            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_level  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
                case ({w_push, w_pop})
                    2'b10:   r_level <= r_level + LW'(1);
                    2'b01:   r_level <= r_level - LW'(1);
                    default: r_level <= r_level;
                endcase
            end

            if (w_wr && (address == 2'd1)) r_run <= writedata[0];

            if (w_push_req && w_full && !w_flush)
                r_ovf <= 1'b1;
            else if (w_wr && (address == 2'd2) && writedata[18])
                r_ovf <= 1'b0;

            if (w_wr && (address == 2'd3)) r_rest <= writedata[DATA_W-1:0];
        end
    end

`ifdef NIOS_MUSIC_SEQ_IRQ_EN
    logic r_irq_en, r_irq;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr && (address == 2'd1)) r_irq_en <= writedata[2];
            r_irq <= r_irq_en && w_empty && (r_state == S_IDLE);
        end
    end

    assign w_irq_en = r_irq_en;
    assign irq      = r_irq;
`else
    assign w_irq_en = 1'b0;
    assign irq      = 1'b0;
`endif

    always_comb begin
        readdata = '0;
        case (address)
            2'd0: readdata[DATA_W-1:0] = out_port;
            2'd1: begin
                readdata[0] = r_run;
                readdata[2] = w_irq_en;
            end
            2'd2: begin
                readdata[LW-1:0] = r_level;
                readdata[16]     = w_empty;
                readdata[17]     = w_full;
                readdata[18]     = r_ovf;
                readdata[19]     = note_valid;
            end
            default: readdata[DATA_W-1:0] = r_rest;
        endcase
    end
endmodule

// File: tb/tb_nios_ii_music_sequencer.sv
// Directed bench for nios_ii_music_sequencer: register table plus multi-cycle playback sequences.
module tb_nios_ii_music_sequencer;
    localparam int DATA_W = 16;

`ifdef NIOS_MUSIC_SEQ_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif
    localparam logic [31:0] CTRL_IRQ = IRQ_ON ? 32'h4 : 32'h0;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [1:0]        address = '0;
    logic              chipselect = 1'b0;
    logic              write_n = 1'b1;
    logic [31:0]       writedata = '0;
    logic [31:0]       readdata;
    logic [DATA_W-1:0] out_port;
    logic              note_valid, note_start, irq;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_q[$];
    int          exp_len_q[$];

    typedef struct {
        logic        is_wr;
        logic [1:0]  addr;
        logic [31:0] data;
    } vec_t;

    vec_t vecs[$];

    nios_ii_music_sequencer #(
        .DATA_W(16), .DUR_W(16), .DEPTH(4), .TICK_DIV(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .out_port(out_port), .note_valid(note_valid), .note_start(note_start), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd_check(input string name, input logic [1:0] a, input logic [31:0] exp);
        @(negedge clk);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        check(name, readdata, exp);
        chipselect = 1'b0;
    endtask

    function automatic vec_t mk(input logic w, input logic [1:0] a, input logic [31:0] d);
        vec_t v;
        v.is_wr = w;
        v.addr  = a;
        v.data  = d;
        return v;
    endfunction

    // Samples n cycles of out_port, compresses into runs and compares with exp_q/exp_len_q.
    task automatic run_segments(input string name, input int n_cycles, input int exp_starts);
        logic [31:0] vals[$];
        int          lens[$];
        int          starts;
        int          n;
        starts = 0;
        for (int i = 0; i < n_cycles; i++) begin
            #1;
            if (note_start) starts++;
            if (vals.size() == 0 || 32'(out_port) != vals[vals.size()-1]) begin
                vals.push_back(32'(out_port));
                lens.push_back(1);
            end else begin
                lens[lens.size()-1] = lens[lens.size()-1] + 1;
            end
            @(negedge clk);
        end
        check({name, " nsegs"}, 32'(vals.size()), 32'(exp_q.size()));
        n = (vals.size() < exp_q.size()) ? vals.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s seg%0d val", name, i), vals[i], exp_q[i]);
            check($sformatf("%s seg%0d len", name, i), 32'(lens[i]), 32'(exp_len_q[i]));
        end
        check({name, " starts"}, 32'(starts), 32'(exp_starts));
    endtask

    initial begin
        vecs.push_back(mk(0, 2'd0, 32'h0000_0000));
        vecs.push_back(mk(0, 2'd1, 32'h0000_0000));
        vecs.push_back(mk(0, 2'd2, 32'h0001_0000));
        vecs.push_back(mk(0, 2'd3, 32'h0000_0000));
        vecs.push_back(mk(1, 2'd3, 32'h0000_0055));
        vecs.push_back(mk(0, 2'd0, 32'h0000_0055));
        vecs.push_back(mk(0, 2'd3, 32'h0000_0055));
        vecs.push_back(mk(1, 2'd3, 32'hFFFF_ABCD));
        vecs.push_back(mk(0, 2'd3, 32'h0000_ABCD));
        vecs.push_back(mk(0, 2'd0, 32'h0000_ABCD));
        vecs.push_back(mk(1, 2'd1, 32'h0000_0006));
        vecs.push_back(mk(0, 2'd1, CTRL_IRQ));
        vecs.push_back(mk(1, 2'd1, 32'h0000_0000));
        vecs.push_back(mk(0, 2'd1, 32'h0000_0000));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(1, 2'd0, 32'h0001_0011 + 32'(i)));
        vecs.push_back(mk(0, 2'd2, 32'h0006_0004));
        vecs.push_back(mk(0, 2'd0, 32'h0000_ABCD));
        vecs.push_back(mk(1, 2'd2, 32'h0004_0000));
        vecs.push_back(mk(0, 2'd2, 32'h0002_0004));
        vecs.push_back(mk(1, 2'd2, 32'hFFFB_FFFF));
        vecs.push_back(mk(0, 2'd2, 32'h0002_0004));
        vecs.push_back(mk(1, 2'd0, 32'h0001_0099));
        vecs.push_back(mk(0, 2'd2, 32'h0006_0004));
        vecs.push_back(mk(1, 2'd1, 32'h0000_0002));
        vecs.push_back(mk(0, 2'd2, 32'h0005_0000));
        vecs.push_back(mk(0, 2'd1, 32'h0000_0000));
        vecs.push_back(mk(1, 2'd2, 32'h0004_0000));
        vecs.push_back(mk(0, 2'd2, 32'h0001_0000));
        vecs.push_back(mk(1, 2'd3, 32'h0000_0000));
        vecs.push_back(mk(0, 2'd0, 32'h0000_0000));

        // clock / reset
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("reset out_port", 32'(out_port), 32'h0);
        check("reset note_valid", 32'(note_valid), 32'h0);
        check("reset note_start", 32'(note_start), 32'h0);
        check("reset irq", 32'(irq), 32'h0);

        foreach (vecs[i]) begin
            if (vecs[i].is_wr) bus_write(vecs[i].addr, vecs[i].data);
            else rd_check($sformatf("vec%0d addr%0d", i, vecs[i].addr), vecs[i].addr, vecs[i].data);
        end

        // basic play
        bus_write(2'd0, 32'h0002_0041);
        bus_write(2'd1, 32'h1);
        exp_q     = '{32'h0, 32'h41, 32'h0};
        exp_len_q = '{1, 8, 11};
        run_segments("basic", 20, 1);
        check("basic note_valid end", 32'(note_valid), 32'h0);
        rd_check("basic status end", 2'd2, 32'h0001_0000);

        // gapless sequence, duration 0 treated as 1
        bus_write(2'd1, 32'h0);
        bus_write(2'd0, 32'h0001_0010);
        bus_write(2'd0, 32'h0003_0020);
        bus_write(2'd0, 32'h0000_0030);
        bus_write(2'd1, 32'h1);
        exp_q     = '{32'h0, 32'h10, 32'h20, 32'h30, 32'h0};
        exp_len_q = '{1, 4, 12, 4, 9};
        run_segments("gapless", 30, 3);

        // abort by clearing run, FIFO contents kept
        bus_write(2'd1, 32'h0);
        bus_write(2'd3, 32'h5);
        bus_write(2'd0, 32'h000A_0077);
        bus_write(2'd0, 32'h0001_0088);
        bus_write(2'd1, 32'h1);
        repeat (6) @(negedge clk);
        #1;
        check("abort pre out_port", 32'(out_port), 32'h77);
        check("abort pre note_valid", 32'(note_valid), 32'h1);
        rd_check("abort pre status", 2'd2, 32'h0008_0001);
        bus_write(2'd1, 32'h0);
        @(negedge clk);
        #1;
        check("abort out_port", 32'(out_port), 32'h5);
        check("abort note_valid", 32'(note_valid), 32'h0);
        rd_check("abort status", 2'd2, 32'h0000_0001);
        bus_write(2'd1, 32'h1);
        repeat (10) @(negedge clk);
        rd_check("resume drained", 2'd2, 32'h0001_0000);

        // flush during play, run latched with flush
        bus_write(2'd0, 32'h000A_0099);
        bus_write(2'd0, 32'h000A_00AA);
        repeat (5) @(negedge clk);
        #1;
        check("flush pre out_port", 32'(out_port), 32'h99);
        bus_write(2'd1, 32'h3);
        @(negedge clk);
        #1;
        check("flush note_valid", 32'(note_valid), 32'h0);
        check("flush out_port", 32'(out_port), 32'h5);
        rd_check("flush status", 2'd2, 32'h0001_0000);
        rd_check("flush ctrl", 2'd1, 32'h1);
        repeat (3) @(negedge clk);
        #1;
        check("flush stays idle", 32'(note_valid), 32'h0);

        // reset mid-play
        bus_write(2'd0, 32'h000A_00BB);
        repeat (3) @(negedge clk);
        #1;
        check("rst pre note_valid", 32'(note_valid), 32'h1);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rst out_port", 32'(out_port), 32'h0);
        check("rst note_valid", 32'(note_valid), 32'h0);
        check("rst note_start", 32'(note_start), 32'h0);
        check("rst irq", 32'(irq), 32'h0);
        rd_check("rst ctrl", 2'd1, 32'h0);
        rd_check("rst rest", 2'd3, 32'h0);
        rd_check("rst status", 2'd2, 32'h0001_0000);

        // interrupt behaviour (stays low when the feature is not built)
        bus_write(2'd1, 32'h4);
        @(negedge clk);
        #1;
        check("irq en empty", 32'(irq), 32'(IRQ_ON));
        bus_write(2'd0, 32'h0001_00CC);
        #1;
        check("irq push same cycle", 32'(irq), 32'(IRQ_ON));
        @(negedge clk);
        #1;
        check("irq after push", 32'(irq), 32'h0);
        bus_write(2'd1, 32'h5);
        repeat (10) @(negedge clk);
        #1;
        check("irq after note", 32'(irq), 32'(IRQ_ON));
        bus_write(2'd1, 32'h1);
        @(negedge clk);
        #1;
        check("irq en cleared", 32'(irq), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
